// File: rtl/riscv_mpsoc_pkg.sv
// Shared definitions for the riscv_mpsoc core stages.
// Contents:
//   - major opcodes used to classify instructions (instr[6:0])
//   - INSTR_NOP: canonical "addi x0,x0,0" used to fill empty pipeline slots
//   - data-memory access size encodings (match func3[1:0] of loads/stores)
//   - CAUSE_* bit indices into the exception vector
package riscv_mpsoc_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   localparam logic [2:0] BYTE  = 3'b000;
   localparam logic [2:0] HWORD = 3'b001;
   localparam logic [2:0] WORD  = 3'b010;
   localparam logic [2:0] DWORD = 3'b011;

   localparam int CAUSE_MISALIGNED_INSTRUCTION   = 0;
   localparam int CAUSE_INSTRUCTION_ACCESS_FAULT = 1;
   localparam int CAUSE_ILLEGAL_INSTRUCTION      = 2;
   localparam int CAUSE_BREAKPOINT               = 3;
   localparam int CAUSE_MISALIGNED_LOAD          = 4;
   localparam int CAUSE_LOAD_ACCESS_FAULT        = 5;
   localparam int CAUSE_MISALIGNED_STORE         = 6;
   localparam int CAUSE_STORE_ACCESS_FAULT       = 7;
   localparam int CAUSE_UMODE_ECALL              = 8;
   localparam int CAUSE_SMODE_ECALL              = 9;
   localparam int CAUSE_HMODE_ECALL              = 10;
   localparam int CAUSE_MMODE_ECALL              = 11;

endpackage

// File: rtl/riscv_mem.sv
// riscv_mem: memory-access pipeline stage between execute and write-back.
// Registers the EX results onto the mem_* bus consumed by write-back and
// issues a single one-cycle data-memory request per valid load/store.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   mem_stall_o             stall to EX and earlier (mirrors wb_stall_i)
//   wb_stall_i              write-back is waiting on memory
//   wb_exception_i/bubble_i state of the write-back slot (flush source)
//   ex_*                    results from the execute stage
//   mem_*                   registered stage outputs to write-back
//   dmem_*                  data-memory request (req strobe, we, address,
//                           size, size-replicated store data)
module riscv_mem
   import riscv_mpsoc_pkg::*;
#(
   parameter int               XLEN           = 64,
   parameter int               ILEN           = 64,
   parameter int               EXCEPTION_SIZE = 16,
   parameter logic [XLEN-1:0]  PC_INIT        = 'h8000_0000
)(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   output logic                      mem_stall_o,
   input  logic                      wb_stall_i,
   input  logic [EXCEPTION_SIZE-1:0] wb_exception_i,
   input  logic                      wb_bubble_i,
   input  logic [XLEN-1:0]           ex_pc_i,
   input  logic [ILEN-1:0]           ex_instr_i,
   input  logic                      ex_bubble_i,
   input  logic [EXCEPTION_SIZE-1:0] ex_exception_i,
   input  logic [XLEN-1:0]           ex_r_i,
   input  logic [XLEN-1:0]           ex_memadr_i,
   input  logic [XLEN-1:0]           ex_opB_i,
   output logic [XLEN-1:0]           mem_pc_o,
   output logic [ILEN-1:0]           mem_instr_o,
   output logic                      mem_bubble_o,
   output logic [EXCEPTION_SIZE-1:0] mem_exception_o,
   output logic [XLEN-1:0]           mem_r_o,
   output logic [XLEN-1:0]           mem_memadr_o,
   output logic                      dmem_req_o,
   output logic                      dmem_we_o,
   output logic [XLEN-1:0]           dmem_adr_o,
   output logic [2:0]                dmem_size_o,
   output logic [XLEN-1:0]           dmem_d_o
);

   // Store data is replicated across the bus so the memory can pick the
   // lane by address without a shifter. With XLEN=32 the word case is
   // naturally a single copy.
   function automatic logic [XLEN-1:0] store_data(input logic [XLEN-1:0] d,
                                                  input logic [1:0]      sz);
      logic [XLEN-1:0] res;
      res = d;
      case (sz)
         2'b00:   for (int i = 0; i < XLEN/8;  i++) res[i*8  +: 8]  = d[7:0];
         2'b01:   for (int i = 0; i < XLEN/16; i++) res[i*16 +: 16] = d[15:0];
         2'b10:   for (int i = 0; i < XLEN/32; i++) res[i*32 +: 32] = d[31:0];
         default: res = d;
      endcase
      return res;
   endfunction

   logic [XLEN-1:0]           pc_q, pc_d;
   logic [ILEN-1:0]           instr_q, instr_d;
   logic                      bubble_q, bubble_d;
   logic [EXCEPTION_SIZE-1:0] exc_q, exc_d;
   logic [XLEN-1:0]           r_q, r_d;
   logic [XLEN-1:0]           memadr_q, memadr_d;
   logic                      req_q, req_d;
   logic                      we_q, we_d;
   logic [XLEN-1:0]           dadr_q, dadr_d;
   logic [2:0]                size_q, size_d;
   logic [XLEN-1:0]           dd_q, dd_d;

   logic [6:0] opcode;
   logic [2:0] func3;
   logic       flush;
   logic       is_mem_op;
   logic       issue;

   assign opcode    = ex_instr_i[6:0];
   assign func3     = ex_instr_i[14:12];
   assign is_mem_op = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
   assign issue     = ~ex_bubble_i & ~(|ex_exception_i) & is_mem_op;

   // An older instruction with an exception, either already in WB or
   // sitting in this stage, kills whatever EX hands over.
   assign flush = ((|wb_exception_i) & ~wb_bubble_i) |
                  ((|exc_q) & ~bubble_q);

   assign mem_stall_o = wb_stall_i;

   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      bubble_d = bubble_q;
      exc_d    = exc_q;
      r_d      = r_q;
      memadr_d = memadr_q;
      req_d    = 1'b0;   // strobe lasts exactly one cycle
      we_d     = we_q;
      dadr_d   = dadr_q;
      size_d   = size_q;
      dd_d     = dd_q;

      if (flush) begin
         // Flush wins over stall: the held instruction is discarded anyway.
         pc_d     = ex_pc_i;
         instr_d  = ex_instr_i;
         bubble_d = 1'b1;
         exc_d    = '0;
         r_d      = ex_r_i;
         memadr_d = ex_memadr_i;
      end else if (!wb_stall_i) begin
         pc_d     = ex_pc_i;
         instr_d  = ex_instr_i;
         bubble_d = ex_bubble_i;
         exc_d    = ex_exception_i;
         r_d      = ex_r_i;
         memadr_d = ex_memadr_i;
         if (issue) begin
            req_d  = 1'b1;
            we_d   = (opcode == OPC_STORE);
            dadr_d = ex_memadr_i;
            size_d = {1'b0, func3[1:0]};
            dd_d   = (opcode == OPC_STORE) ? store_data(ex_opB_i, func3[1:0])
                                           : ex_opB_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q     <= PC_INIT;
         instr_q  <= ILEN'(INSTR_NOP);
         bubble_q <= 1'b1;
         exc_q    <= '0;
         r_q      <= '0;
         memadr_q <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         dadr_q   <= '0;
         size_q   <= '0;
         dd_q     <= '0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         bubble_q <= bubble_d;
         exc_q    <= exc_d;
         r_q      <= r_d;
         memadr_q <= memadr_d;
         req_q    <= req_d;
         we_q     <= we_d;
         dadr_q   <= dadr_d;
         size_q   <= size_d;
         dd_q     <= dd_d;
      end
   end

   assign mem_pc_o        = pc_q;
   assign mem_instr_o     = instr_q;
   assign mem_bubble_o    = bubble_q;
   assign mem_exception_o = exc_q;
   assign mem_r_o         = r_q;
   assign mem_memadr_o    = memadr_q;
   assign dmem_req_o      = req_q;
   assign dmem_we_o       = we_q;
   assign dmem_adr_o      = dadr_q;
   assign dmem_size_o     = size_q;
   assign dmem_d_o        = dd_q;

endmodule

// File: tb/tb_riscv_mem.sv
// Self-checking bench for riscv_mem: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level reference model.
module tb_riscv_mem;
   import riscv_mpsoc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_stall;
   logic        wb_stall = 1'b0;
   logic [15:0] wb_exc = '0;
   logic        wb_bubble = 1'b1;
   logic [63:0] ex_pc = '0;
   logic [63:0] ex_instr = 64'h13;
   logic        ex_bubble = 1'b1;
   logic [15:0] ex_exc = '0;
   logic [63:0] ex_r = '0;
   logic [63:0] ex_memadr = '0;
   logic [63:0] ex_opB = '0;
   logic [63:0] mem_pc;
   logic [63:0] mem_instr;
   logic        mem_bubble;
   logic [15:0] mem_exc;
   logic [63:0] mem_r;
   logic [63:0] mem_memadr;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_adr;
   logic [2:0]  dmem_size;
   logic [63:0] dmem_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_mem dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .mem_stall_o     (mem_stall),
      .wb_stall_i      (wb_stall),
      .wb_exception_i  (wb_exc),
      .wb_bubble_i     (wb_bubble),
      .ex_pc_i         (ex_pc),
      .ex_instr_i      (ex_instr),
      .ex_bubble_i     (ex_bubble),
      .ex_exception_i  (ex_exc),
      .ex_r_i          (ex_r),
      .ex_memadr_i     (ex_memadr),
      .ex_opB_i        (ex_opB),
      .mem_pc_o        (mem_pc),
      .mem_instr_o     (mem_instr),
      .mem_bubble_o    (mem_bubble),
      .mem_exception_o (mem_exc),
      .mem_r_o         (mem_r),
      .mem_memadr_o    (mem_memadr),
      .dmem_req_o      (dmem_req),
      .dmem_we_o       (dmem_we),
      .dmem_adr_o      (dmem_adr),
      .dmem_size_o     (dmem_size),
      .dmem_d_o        (dmem_d)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Slot contents as seen by write-back, plus the last memory request.
   logic [63:0] m_pc = 64'h8000_0000;
   logic [63:0] m_instr = 64'h13;
   logic        m_bubble = 1'b1;
   logic [15:0] m_exc = '0;
   logic [63:0] m_r = '0, m_adr = '0;
   logic        m_req = 1'b0, m_we = 1'b0;
   logic [63:0] m_dadr = '0, m_d = '0;
   logic [2:0]  m_size = '0;
   int          n_issued = 0;

   function automatic logic [63:0] replicate(input logic [63:0] v, input logic [1:0] sz);
      case (sz)
         2'd0:    return {56'b0, v[7:0]}  * 64'h0101_0101_0101_0101;
         2'd1:    return {48'b0, v[15:0]} * 64'h0001_0001_0001_0001;
         2'd2:    return {32'b0, v[31:0]} * 64'h0000_0001_0000_0001;
         default: return v;
      endcase
   endfunction

   logic killed;
   logic is_ls;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 64'h8000_0000; m_instr = 64'h13; m_bubble = 1'b1; m_exc = '0;
         m_r = '0; m_adr = '0; m_req = 1'b0; m_we = 1'b0;
         m_dadr = '0; m_d = '0; m_size = '0;
      end else begin
         killed = (wb_exc != 0 && !wb_bubble) || (m_exc != 0 && !m_bubble);
         is_ls  = (ex_instr[6:0] == OPC_LOAD) || (ex_instr[6:0] == OPC_STORE);
         m_req  = 1'b0;
         if (killed || !wb_stall) begin
            m_pc = ex_pc; m_instr = ex_instr; m_r = ex_r; m_adr = ex_memadr;
            m_bubble = killed ? 1'b1 : ex_bubble;
            m_exc    = killed ? 16'h0 : ex_exc;
            if (!killed && !ex_bubble && ex_exc == 0 && is_ls) begin
               m_req  = 1'b1;
               m_we   = (ex_instr[6:0] == OPC_STORE);
               m_dadr = ex_memadr;
               m_size = {1'b0, ex_instr[13:12]};
               m_d    = m_we ? replicate(ex_opB, ex_instr[13:12]) : ex_opB;
               n_issued++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         chk("stall", {63'b0, mem_stall}, {63'b0, wb_stall});
         chk("pc", mem_pc, m_pc);
         chk("instr", mem_instr, m_instr);
         chk("bubble", {63'b0, mem_bubble}, {63'b0, m_bubble});
         chk("exc", {48'b0, mem_exc}, {48'b0, m_exc});
         if (!m_bubble) begin
            chk("r", mem_r, m_r);
            chk("memadr", mem_memadr, m_adr);
         end
         chk("req", {63'b0, dmem_req}, {63'b0, m_req});
         if (m_req) begin
            chk("we", {63'b0, dmem_we}, {63'b0, m_we});
            chk("dadr", dmem_adr, m_dadr);
            chk("size", {61'b0, dmem_size}, {61'b0, m_size});
            if (m_we) chk("wdata", dmem_d, m_d);
         end
         if (dmem_req)
            $display("req we=%0d adr=%h size=%0d d=%h", dmem_we, dmem_adr, dmem_size, dmem_d);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] pc, input logic [63:0] instr, input logic bub,
                        input logic [15:0] exc, input logic [63:0] adr, input logic [63:0] opb);
      ex_pc = pc; ex_instr = instr; ex_bubble = bub; ex_exc = exc;
      ex_r = pc ^ 64'h5555; ex_memadr = adr; ex_opB = opb;
   endtask

   localparam logic [63:0] I_LW  = 64'h0000_2003;
   localparam logic [63:0] I_SB  = 64'h0000_0023;
   localparam logic [63:0] I_ADD = 64'h0000_0033;

   int pulses;
   logic [31:0] ra, rb, rc;

   initial begin
      step(); step();
      chk("rst_pc", mem_pc, 64'h8000_0000);
      chk("rst_bubble", {63'b0, mem_bubble}, 64'd1);
      chk("rst_req", {63'b0, dmem_req}, 64'd0);
      chk("rst_instr", mem_instr, 64'h13);
      rst_n = 1'b1;

      // LW, one-cycle request then deassert
      drive(64'h100, I_LW, 1'b0, 16'h0, 64'h1004, 64'hDEAD_BEEF);
      step();
      chk("lw_req", {63'b0, dmem_req}, 64'd1);
      chk("lw_we", {63'b0, dmem_we}, 64'd0);
      chk("lw_adr", dmem_adr, 64'h1004);
      chk("lw_size", {61'b0, dmem_size}, {61'b0, WORD});
      drive(64'h104, I_ADD, 1'b1, 16'h0, 64'h0, 64'h0);
      step();
      chk("lw_req_off", {63'b0, dmem_req}, 64'd0);

      // SB with write-back stall for 3 cycles
      drive(64'h2000, I_SB, 1'b0, 16'h0, 64'h2003, 64'h1234_5678_9ABC_DEA5);
      step();
      pulses = int'(dmem_req);
      chk("sb_data", dmem_d, 64'hA5A5_A5A5_A5A5_A5A5);
      chk("sb_we", {63'b0, dmem_we}, 64'd1);
      wb_stall = 1'b1;
      drive(64'h3000, I_ADD, 1'b0, 16'h0, 64'h0, 64'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(dmem_req);
         chk("sb_hold_pc", mem_pc, 64'h2000);
         chk("sb_hold_instr", mem_instr, I_SB);
      end
      chk("sb_pulses", 64'(pulses), 64'd1);
      wb_stall = 1'b0;
      step();
      chk("sb_release_pc", mem_pc, 64'h3000);

      // wb exception flushes a valid ADD
      wb_exc = 16'(1) << CAUSE_ILLEGAL_INSTRUCTION; wb_bubble = 1'b0;
      drive(64'h4000, I_ADD, 1'b0, 16'h0, 64'h0, 64'h0);
      step();
      chk("wbx_bubble", {63'b0, mem_bubble}, 64'd1);
      chk("wbx_exc", {48'b0, mem_exc}, 64'd0);
      chk("wbx_req", {63'b0, dmem_req}, 64'd0);
      chk("wbx_pc", mem_pc, 64'h4000);
      wb_exc = '0; wb_bubble = 1'b1;

      // EX exception carried, then younger instruction killed
      drive(64'h5000, I_LW, 1'b0, 16'h4, 64'h1000, 64'h0);
      step();
      chk("exx_exc", {48'b0, mem_exc}, 64'h4);
      chk("exx_bubble", {63'b0, mem_bubble}, 64'd0);
      chk("exx_req", {63'b0, dmem_req}, 64'd0);
      drive(64'h5004, I_ADD, 1'b0, 16'h0, 64'h0, 64'h0);
      step();
      chk("exx_kill_bubble", {63'b0, mem_bubble}, 64'd1);
      chk("exx_kill_exc", {48'b0, mem_exc}, 64'd0);

      // flush beats stall
      drive(64'h6000, I_ADD, 1'b0, 16'h0, 64'h0, 64'h0);
      step();
      chk("fs_pre_bubble", {63'b0, mem_bubble}, 64'd0);
      wb_stall = 1'b1; wb_exc = 16'h1; wb_bubble = 1'b0;
      drive(64'h6004, I_ADD, 1'b0, 16'h0, 64'h0, 64'h0);
      step();
      chk("fs_bubble", {63'b0, mem_bubble}, 64'd1);
      chk("fs_pc", mem_pc, 64'h6004);
      wb_stall = 1'b0; wb_exc = '0; wb_bubble = 1'b1;

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         ra = $urandom; rb = $urandom; rc = $urandom;
         case ($urandom_range(0, 3))
            0: ra[6:0] = OPC_LOAD;
            1: ra[6:0] = OPC_STORE;
            2: ra[6:0] = OPC_OP;
            default: ;
         endcase
         drive({rb, rc}, {rc, ra}, ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 15) == 0) ? (16'(1) << $urandom_range(0, 15)) : 16'h0,
               {rc, rb}, {ra, rb});
         wb_stall  = ($urandom_range(0, 3) == 0);
         wb_exc    = ($urandom_range(0, 19) == 0) ? (16'(1) << $urandom_range(0, 15)) : 16'h0;
         wb_bubble = $urandom_range(0, 1) != 0;
         step();
      end
      wb_stall = 1'b0; wb_exc = '0; wb_bubble = 1'b1;
      chk("issued_some", 64'(n_issued > 20), 64'd1);

      // reset in the middle of an outstanding request
      drive(64'h7000, I_LW, 1'b0, 16'h0, 64'h1008, 64'h0);
      step();
      chk("mr_req_before", {63'b0, dmem_req}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_req", {63'b0, dmem_req}, 64'd0);
      chk("mr_pc", mem_pc, 64'h8000_0000);
      chk("mr_bubble", {63'b0, mem_bubble}, 64'd1);
      chk("mr_adr", dmem_adr, 64'd0);
      step();
      rst_n = 1'b1;
      drive(64'h7100, I_ADD, 1'b1, 16'h0, 64'h0, 64'h0);
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_mem.md
Name: riscv_mem

Overview:
- Memory-access pipeline stage between the execute stage and riscv_wb.
- Registers the EX results (pc, instr, bubble, exception, ALU result, memory address) and presents them as the mem_* bus that write-back consumes.
- Issues exactly one data-memory request per non-bubble, exception-free load or store.
- Propagates the write-back stall upstream and kills younger instructions when an older instruction carries an exception.

Parameters:
XLEN, 64, data/address width
ILEN, 64, instruction register width
EXCEPTION_SIZE, 16, width of exception vector
PC_INIT, 'h8000_0000, reset value of mem_pc_o

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mem_stall_o  out  1  stall to EX and earlier stages
wb_stall_i  in  1  stall from write-back (memory wait)
wb_exception_i  in  EXCEPTION_SIZE  exception vector in write-back
wb_bubble_i  in  1  write-back slot is a bubble
ex_pc_i  in  XLEN  EX program counter
ex_instr_i  in  ILEN  EX instruction
ex_bubble_i  in  1  EX slot is a bubble
ex_exception_i  in  EXCEPTION_SIZE  EX exception vector
ex_r_i  in  XLEN  ALU result
ex_memadr_i  in  XLEN  effective load/store address
ex_opB_i  in  XLEN  store data (rs2)
mem_pc_o  out  XLEN  registered pc
mem_instr_o  out  ILEN  registered instruction
mem_bubble_o  out  1  registered bubble flag
mem_exception_o  out  EXCEPTION_SIZE  registered exception vector
mem_r_o  out  XLEN  registered ALU result
mem_memadr_o  out  XLEN  registered effective address
dmem_req_o  out  1  data-memory request strobe, one cycle
dmem_we_o  out  1  1 = store, 0 = load
dmem_adr_o  out  XLEN  request address
dmem_size_o  out  3  BYTE/HWORD/WORD/DWORD encoding
dmem_d_o  out  XLEN  store data, replicated per size

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values:
  - mem_pc_o = PC_INIT
  - mem_instr_o = INSTR_NOP
  - mem_bubble_o = 1
  - mem_exception_o = 0
  - mem_r_o = 0, mem_memadr_o = 0
  - dmem_req_o = 0, dmem_we_o = 0, dmem_adr_o = 0, dmem_size_o = 0, dmem_d_o = 0
- Stall: mem_stall_o = wb_stall_i, combinational. While stalled, all mem_* registers hold.
- Flush condition: flush = (|wb_exception_i & ~wb_bubble_i) | (|mem_exception_o & ~mem_bubble_o).
  - On a flush edge: mem_bubble_o <= 1, mem_exception_o <= 0, and no request is issued. mem_pc_o and mem_instr_o still load from EX.
  - Flush has priority over stall. A flushed load whose ack is still outstanding has that ack ignored, because WB sees a bubble and does not stall.
- Normal edge (no stall, no flush):
  - mem_pc_o, mem_instr_o, mem_r_o and mem_memadr_o load from ex_*.
  - mem_bubble_o <= ex_bubble_i; mem_exception_o <= ex_exception_i.
- Request issue, latency 1:
  - Fires on a normal edge where ex_bubble_i = 0, ex_exception_i = 0 and opcode ∈ {OPC_LOAD, OPC_STORE}.
  - That edge registers dmem_req_o = 1, dmem_we_o = (opcode == OPC_STORE), dmem_adr_o = ex_memadr_i and dmem_size_o from func3[1:0].
  - dmem_req_o deasserts on the next edge, including while wb_stall_i holds the instruction. Never more than one request per instruction.
- Store data: dmem_d_o replicates ex_opB_i by size.
  - byte: 8 copies of [7:0]
  - half: 4 copies of [15:0]
  - word: 2 copies of [31:0]
  - dword: as-is
  - XLEN = 32: dword is illegal; treat word as as-is.
- Loads: dmem_d_o is don't-care; drive ex_opB_i.
- Reset mid-request: all outputs return to reset values immediately; no request survives.

Decomposition:
- Shared package riscv_mpsoc_pkg holds: opcodes (OPC_LOAD, OPC_STORE), INSTR_NOP, the BYTE/HWORD/WORD/DWORD size encodings, and the CAUSE_* indices.
- No sub-module. A local function (size decode, store replication) is sufficient.

Test Plan:
- Reset: rst_ni low mid-cycle -> mem_pc_o = 'h8000_0000, mem_bubble_o = 1, dmem_req_o = 0 asynchronously.
- LW, addr 'h1004, ex_opB_i = 'hDEADBEEF, no stall -> next cycle dmem_req_o = 1, we = 0, adr = 'h1004, size = WORD; following cycle dmem_req_o = 0.
- SB, opB = 'h..A5, wb_stall_i held high 3 cycles -> dmem_d_o = 'hA5A5A5A5A5A5A5A5; exactly one dmem_req_o pulse; mem_* registers hold for 3 cycles.
- wb_exception_i bit set and wb_bubble_i = 0 while EX holds a valid ADD -> mem_bubble_o = 1, mem_exception_o = 0, no request.
- EX instruction with ex_exception_i[illegal] = 1 -> mem_exception_o carries the bit, no request; next EX instruction is registered as a bubble.
- Flush asserted while wb_stall_i = 1 -> mem_bubble_o = 1 on that edge (flush beats stall).
